// File: rtl/purchase_if.sv
// Bus bundle between the purchase controller, its customer-facing inputs and
// the item memory. The controller uses the slave view.
interface purchase_if #(
  parameter int MAX_ITEMS = 1024
);
  localparam int IW = $clog2(MAX_ITEMS);

  logic          sel_valid;
  logic [IW-1:0] sel_index;
  logic          coin_valid;
  logic [15:0]   coin_value;
  logic          cancel;
  logic [IW-1:0] mem_raddr;
  logic [15:0]   mem_item_price;
  logic [7:0]    mem_avail_count;
  logic          dispense_valid;
  logic [IW-1:0] dispensed_item_index;
  logic          change_valid;
  logic [15:0]   change_amount;
  logic          sold_out;
  logic          busy;

  modport slave (
    input  sel_valid, sel_index, coin_valid, coin_value, cancel,
           mem_item_price, mem_avail_count,
    output mem_raddr, dispense_valid, dispensed_item_index,
           change_valid, change_amount, sold_out, busy
  );

  modport master (
    output sel_valid, sel_index, coin_valid, coin_value, cancel,
           mem_item_price, mem_avail_count,
    input  mem_raddr, dispense_valid, dispensed_item_index,
           change_valid, change_amount, sold_out, busy
  );
endinterface

// File: rtl/purchase_controller.sv
// Vending purchase controller: select an item, read its price and stock,
// collect coins with timeout, dispense, and return change or refund.
module purchase_controller #(
  parameter int MAX_ITEMS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic     clk,
  input  logic     rst,
  purchase_if.slave bus
);
  localparam int IW = $clog2(MAX_ITEMS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, COLLECT, DISPENSE, CHANGE
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] raddr_q, raddr_next;
  logic [IW-1:0] index_q, index_next;
  logic [IW-1:0] dispensed_q, dispensed_next;
  logic [15:0]   credit_q, credit_next;
  logic [15:0]   price_q, price_next;
  logic [TW-1:0] timer_q, timer_next;
  logic          dispense_q, dispense_next;
  logic          change_valid_q, change_valid_next;
  logic [15:0]   change_amount_q, change_amount_next;
  logic          sold_out_q, sold_out_next;

  logic [16:0]   credit_sum;
  logic [15:0]   credit_in;

  // Credit including this cycle's coin, saturating at 0xFFFF.
  assign credit_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign credit_in  = !bus.coin_valid ? credit_q :
                      (credit_sum[16] ? 16'hFFFF : credit_sum[15:0]);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next         = state;
    raddr_next         = raddr_q;
    index_next         = index_q;
    dispensed_next     = dispensed_q;
    credit_next        = credit_q;
    price_next         = price_q;
    timer_next         = timer_q;
    dispense_next      = 1'b0;
    change_valid_next  = 1'b0;
    change_amount_next = change_amount_q;
    sold_out_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.sel_valid) begin
          raddr_next  = bus.sel_index;
          index_next  = bus.sel_index;
          credit_next = '0;
          state_next  = LOOKUP;
        end
      end
      LOOKUP: state_next = CHECK;
      CHECK: begin
        price_next = bus.mem_item_price;
        timer_next = '0;
        if (bus.mem_avail_count == 8'd0) begin
          sold_out_next = 1'b1;
          state_next    = IDLE;
        end else begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        credit_next = credit_in;
        timer_next  = bus.coin_valid ? '0 : timer_q + TW'(1);
        // Cancel wins over dispense; a same-cycle coin is part of the refund.
        if (bus.cancel || (!bus.coin_valid && timer_q == TIMEOUT_LAST &&
                           credit_q < price_q)) begin
          state_next = IDLE;
          if (credit_in != 16'd0) begin
            change_valid_next  = 1'b1;
            change_amount_next = credit_in;
          end
        end else if (credit_q >= price_q) begin
          state_next     = DISPENSE;
          dispense_next  = 1'b1;
          dispensed_next = index_q;
        end
      end
      DISPENSE: begin
        state_next = CHANGE;
        if (credit_q != price_q) begin
          change_valid_next  = 1'b1;
          change_amount_next = credit_q - price_q;
        end
      end
      CHANGE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the synchronous reset covers all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      raddr_q         <= '0;
      index_q         <= '0;
      dispensed_q     <= '0;
      credit_q        <= '0;
      price_q         <= '0;
      timer_q         <= '0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      sold_out_q      <= 1'b0;
    end else begin
      state           <= state_next;
      raddr_q         <= raddr_next;
      index_q         <= index_next;
      dispensed_q     <= dispensed_next;
      credit_q        <= credit_next;
      price_q         <= price_next;
      timer_q         <= timer_next;
      dispense_q      <= dispense_next;
      change_valid_q  <= change_valid_next;
      change_amount_q <= change_amount_next;
      sold_out_q      <= sold_out_next;
    end
  end

  assign bus.mem_raddr            = raddr_q;
  assign bus.dispense_valid       = dispense_q;
  assign bus.dispensed_item_index = dispensed_q;
  assign bus.change_valid         = change_valid_q;
  assign bus.change_amount        = change_amount_q;
  assign bus.sold_out             = sold_out_q;
  assign bus.busy                 = (state != IDLE);
endmodule

// File: tb/tb_purchase_controller.sv
// Self-checking bench for purchase_controller: directed vector table plus
// hand-written sequences for latency, timeout and mid-transaction reset.
module tb_purchase_controller;
  localparam int MAX_ITEMS = 16;
  localparam int IW        = $clog2(MAX_ITEMS);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  purchase_if #(.MAX_ITEMS(MAX_ITEMS)) bus ();

  purchase_controller #(.MAX_ITEMS(MAX_ITEMS), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Item memory model with one-clock registered read.
  logic [15:0] price_tab [MAX_ITEMS];
  logic [7:0]  stock_tab [MAX_ITEMS];
  always @(posedge clk) begin
    bus.mem_item_price  <= price_tab[bus.mem_raddr];
    bus.mem_avail_count <= stock_tab[bus.mem_raddr];
  end

  typedef struct {
    logic          sel;
    logic [IW-1:0] idx;
    logic          coin;
    logic [15:0]   val;
    logic          cancel;
    logic          busy;
    logic          dv;
    logic [IW-1:0] didx;
    logic          cv;
    logic [15:0]   camt;
    logic          so;
    logic [IW-1:0] raddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sel, input int idx, input logic coin,
                     input int val, input logic cancel, input logic busy,
                     input logic dv, input int didx, input logic cv,
                     input int camt, input logic so, input int raddr);
    vec_t v;
    v.sel = sel;     v.idx = IW'(idx);   v.coin = coin;  v.val = 16'(val);
    v.cancel = cancel; v.busy = busy;    v.dv = dv;      v.didx = IW'(didx);
    v.cv = cv;       v.camt = 16'(camt); v.so = so;      v.raddr = IW'(raddr);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input int idx, input logic coin,
                       input int val, input logic cancel);
    bus.sel_valid  = sel;
    bus.sel_index  = IW'(idx);
    bus.coin_valid = coin;
    bus.coin_value = 16'(val);
    bus.cancel     = cancel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select_and_enter_collect(input int idx);
    drive(1, idx, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  int lat;
  int pulses;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < MAX_ITEMS; i++) begin
      price_tab[i] = 16'd100;
      stock_tab[i] = 8'd1;
    end
    price_tab[2]  = 16'd0;    stock_tab[2]  = 8'd1;
    price_tab[3]  = 16'd50;   stock_tab[3]  = 8'd2;
    price_tab[5]  = 16'd30;   stock_tab[5]  = 8'd4;
    price_tab[7]  = 16'd40;   stock_tab[7]  = 8'd0;
    price_tab[9]  = 16'd60;   stock_tab[9]  = 8'd1;
    price_tab[11] = 16'd100;  stock_tab[11] = 8'd3;
    price_tab[12] = 16'hFFFF; stock_tab[12] = 8'd1;

    // Slot 3, exact payment 20+20+10; a mid-transaction select is ignored.
    add(1,3,0,0,0,  1,0,0,0,0,0,3);
    add(0,0,0,0,0,  1,0,0,0,0,0,3);
    add(0,0,0,0,0,  1,0,0,0,0,0,3);
    add(0,0,1,20,0, 1,0,0,0,0,0,3);
    add(1,9,1,20,0, 1,0,0,0,0,0,3);
    add(0,0,1,10,0, 1,0,0,0,0,0,3);
    add(0,0,0,0,0,  1,1,3,0,0,0,3);
    add(0,0,0,0,0,  1,0,0,0,0,0,3);
    add(0,0,0,0,0,  0,0,0,0,0,0,3);
    add(0,0,1,10,1, 0,0,0,0,0,0,3);
    // Slot 5, overpay 50 on price 30 -> change 20 right after dispense.
    add(1,5,0,0,0,  1,0,0,0,0,0,5);
    add(0,0,0,0,0,  1,0,0,0,0,0,5);
    add(0,0,0,0,0,  1,0,0,0,0,0,5);
    add(0,0,1,50,0, 1,0,0,0,0,0,5);
    add(0,0,0,0,0,  1,1,5,0,0,0,5);
    add(0,0,0,0,0,  1,0,0,1,20,0,5);
    add(0,0,0,0,0,  0,0,0,0,0,0,5);
    // Slot 7 has no stock.
    add(1,7,0,0,0,  1,0,0,0,0,0,7);
    add(0,0,0,0,0,  1,0,0,0,0,0,7);
    add(0,0,0,0,0,  0,0,0,0,0,1,7);
    add(0,0,0,0,0,  0,0,0,0,0,0,7);
    // Slot 9, coin 20 then coin 10 with cancel -> refund 30.
    add(1,9,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,1,20,0, 1,0,0,0,0,0,9);
    add(0,0,1,10,1, 0,0,0,1,30,0,9);
    add(0,0,0,0,0,  0,0,0,0,0,0,9);
    // Cancel with zero credit -> no refund pulse.
    add(1,9,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,0,0,0,  1,0,0,0,0,0,9);
    add(0,0,0,0,1,  0,0,0,0,0,0,9);
    // Slot 12, credit saturates at 0xFFFF and is refunded on cancel.
    add(1,12,0,0,0,      1,0,0,0,0,0,12);
    add(0,0,0,0,0,       1,0,0,0,0,0,12);
    add(0,0,0,0,0,       1,0,0,0,0,0,12);
    add(0,0,1,'hFFF0,0,  1,0,0,0,0,0,12);
    add(0,0,1,'h0020,1,  0,0,0,1,'hFFFF,0,12);

    // Reset state.
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    check("reset busy",          bus.busy, 0);
    check("reset dispense",      bus.dispense_valid, 0);
    check("reset change_valid",  bus.change_valid, 0);
    check("reset sold_out",      bus.sold_out, 0);
    check("reset raddr",         bus.mem_raddr, 0);
    check("reset change_amount", bus.change_amount, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sel, vq[i].idx, vq[i].coin, vq[i].val, vq[i].cancel);
      tick();
      check($sformatf("row%0d busy", i),     bus.busy, vq[i].busy);
      check($sformatf("row%0d dispense", i), bus.dispense_valid, vq[i].dv);
      check($sformatf("row%0d change", i),   bus.change_valid, vq[i].cv);
      check($sformatf("row%0d sold_out", i), bus.sold_out, vq[i].so);
      check($sformatf("row%0d raddr", i),    bus.mem_raddr, vq[i].raddr);
      if (vq[i].dv)
        check($sformatf("row%0d disp_idx", i), bus.dispensed_item_index, vq[i].didx);
      if (vq[i].cv)
        check($sformatf("row%0d change_amt", i), bus.change_amount, vq[i].camt);
    end
    drive(0, 0, 0, 0, 0);

    // Price 0 slot: dispense_valid arrives in the fourth cycle after the
    // selecting edge (LOOKUP=1, CHECK=2, COLLECT=3, DISPENSE=4).
    drive(1, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    lat = 1;
    while (!bus.dispense_valid && lat <= 10) begin
      tick();
      lat++;
    end
    check("latency cycles", lat, 4);
    check("latency disp_idx", bus.dispensed_item_index, 2);
    tick();
    check("zero change no pulse", bus.change_valid, 0);
    check("zero change busy", bus.busy, 1);
    tick();
    check("zero change idle", bus.busy, 0);
    check("single dispense pulse", bus.dispense_valid, 0);

    // Timeout: coin 10 then 8 quiet cycles in COLLECT -> refund 10.
    select_and_enter_collect(11);
    drive(0, 0, 1, 10, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.change_valid || !bus.busy) pulses++;
    end
    check("timeout early exit", pulses, 0);
    tick();
    check("timeout change_valid", bus.change_valid, 1);
    check("timeout change_amt",   bus.change_amount, 10);
    check("timeout busy",         bus.busy, 0);
    check("timeout no dispense",  bus.dispense_valid, 0);
    tick();
    check("timeout pulse width",  bus.change_valid, 0);

    // Reset in COLLECT with credit held: everything back to reset values.
    select_and_enter_collect(11);
    drive(0, 0, 1, 40, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    check("midrst busy",          bus.busy, 0);
    check("midrst dispense",      bus.dispense_valid, 0);
    check("midrst change_valid",  bus.change_valid, 0);
    check("midrst sold_out",      bus.sold_out, 0);
    check("midrst raddr",         bus.mem_raddr, 0);
    check("midrst disp_idx",      bus.dispensed_item_index, 0);
    check("midrst change_amount", bus.change_amount, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.dispense_valid || bus.change_valid || bus.sold_out || bus.busy)
        pulses++;
    end
    check("midrst quiet after", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/purchase_controller.md
PURCHASE_CONTROLLER -- requirements
Module: purchase_controller

Interface
REQ-001 SHALL have parameter MAX_ITEMS, default 1024: number of item slots; index width IW = $clog2(MAX_ITEMS).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before auto-cancel.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sel_valid  input  1  item selection strobe.
REQ-006 SHALL have port sel_index  input  IW  selected item slot.
REQ-007 SHALL have port coin_valid  input  1  coin inserted this cycle.
REQ-008 SHALL have port coin_value  input  16  coin value.
REQ-009 SHALL have port cancel  input  1  customer cancel request.
REQ-010 SHALL have port mem_raddr  output  IW  item memory read address, registered.
REQ-011 SHALL have port mem_item_price  input  16  item memory price; valid one clock after mem_raddr is stable.
REQ-012 SHALL have port mem_avail_count  input  8  item memory stock; same timing as price.
REQ-013 SHALL have port dispense_valid  output  1  one-cycle dispense pulse to item memory.
REQ-014 SHALL have port dispensed_item_index  output  IW  slot being dispensed; valid with dispense_valid.
REQ-015 SHALL have port change_valid  output  1  one-cycle change/refund pulse.
REQ-016 SHALL have port change_amount  output  16  change/refund value; valid with change_valid.
REQ-017 SHALL have port sold_out  output  1  one-cycle pulse: selected item has zero stock.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, LOOKUP, CHECK, COLLECT, DISPENSE, CHANGE.
REQ-020 IDLE: sel_valid SHALL latch sel_index into mem_raddr and the index register, clear credit, go to LOOKUP; coin_valid and cancel in IDLE SHALL be ignored.
REQ-021 LOOKUP SHALL last exactly one cycle with mem_raddr held, then go to CHECK.
REQ-022 CHECK SHALL sample mem_item_price/mem_avail_count into internal registers; if avail = 0 -> pulse sold_out, go IDLE; else go COLLECT.
REQ-023 COLLECT: on coin_valid, credit SHALL increase by coin_value, saturating at 0xFFFF; the timeout counter SHALL clear on any coin.
REQ-024 COLLECT: when registered credit >= latched price (including price 0 on COLLECT entry) -> go DISPENSE next cycle.
REQ-025 COLLECT: cancel, or timeout counter reaching TIMEOUT_CYCLES-1, SHALL go IDLE with change_valid=1, change_amount=credit if credit > 0, with no dispense.
REQ-026 Cancel and coin_valid in the same cycle: the coin SHALL be added and the full sum refunded; cancel SHALL take priority over a dispense transition in the same cycle.
REQ-027 DISPENSE SHALL assert dispense_valid for exactly one cycle with dispensed_item_index = latched index, then go CHANGE.
REQ-028 CHANGE SHALL pulse change_valid one cycle with change_amount = credit - price if nonzero (no pulse if zero), then go IDLE.
REQ-029 sel_valid while busy SHALL be ignored; selection cannot change mid-transaction.
REQ-030 Selection to dispense_valid latency with exact payment already reached SHALL be: LOOKUP, CHECK, COLLECT, DISPENSE = dispense_valid 4 cycles after the sel_valid edge.
REQ-031 Pulse outputs SHALL be registered and never high for more than one consecutive cycle.

Reset
REQ-032 rst SHALL force state IDLE, credit 0, timeout counter 0, mem_raddr 0, dispensed_item_index 0, change_amount 0, and dispense_valid, change_valid, sold_out, busy to 0.
REQ-033 rst mid-transaction SHALL abort with no dispense and no refund pulse; held credit is lost.

Verification
REQ-034 Slot 3: price 50, stock 2; select 3, coins 20+20+10 -> one dispense_valid, index 3, no change_valid, busy low after.
REQ-035 Slot 5: price 30; coin 50 -> dispense_valid then next cycle change_valid, change_amount 20.
REQ-036 Slot 7: stock 0; select 7 -> sold_out pulse at CHECK, no dispense, IDLE.
REQ-037 Coin 10 and cancel in same cycle after a prior coin 20 -> change_amount 30, no dispense.
REQ-038 TIMEOUT_CYCLES=8, coin 10, no activity -> refund 10 after 8 idle cycles; rst mid-COLLECT -> all outputs at reset values, no pulses.
